alu_flag_pipeline_stage: RTL and testbench
==========================================

// Module: alu_flag_pipeline_stage
// PURPOSE
//  Registered output stage directly downstream of the 16-bit arithmetic unit.
//  - Captures result/cout/overflow each cycle, derives N/Z/C/V flags.
//  - Maintains the architectural status-flag register.
//  - Presents a valid/ready stream to writeback through a 2-entry skid buffer,
//    so in_ready never depends combinationally on out_ready.
// PARAMETERS
//  DATA_W   16  datapath width; flags use bit DATA_W-1 as sign
//  SKID_D   2   buffer depth (fixed 2; other values are illegal, elaborate-time $error)
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous reset, active-high
//  in_valid       in   1       upstream transaction present
//  in_ready       out  1       stage can accept (registered)
//  in_ctrl        in   3       alu_pkg ARITH_* opcode of the transaction
//  in_result      in   DATA_W  arithmetic unit result (0 for ARITH_CMP)
//  in_cout        in   1       arithmetic unit carry out
//  in_overflow    in   1       arithmetic unit signed overflow
//  in_cmp_eq      in   1       a==b from datapath comparator (used for CMP only)
//  in_cmp_n       in   1       sign bit of a-b (used for CMP only)
//  flag_clr       in   1       clear status_flags (and sticky) next edge
//  out_valid      out  1       downstream transaction present
//  out_ready      in   1       downstream accepts
//  out_result     out  DATA_W  registered result
//  out_wr_en      out  1       1 = write result to regfile; 0 for CMP
//  out_flags      out  4       {N,Z,C,V} of this transaction
//  status_flags   out  4       architectural {N,Z,C,V}, last accepted op
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_result=0, out_wr_en=0, out_flags=0,
//   status_flags=0, both buffer entries empty, rd/wr pointers=0.
//  Handshake: accept when in_valid&in_ready; emit when out_valid&out_ready.
//   out_* are held stable while out_valid&!out_ready.
//  Latency: accepted at edge k -> out_valid=1 after edge k (1 cycle), if empty.
//  Buffer: 2 entries, 1-bit pointers wrap 1->0, 2-bit count 0..2.
//   in_ready = (count<2), registered from next count.
//   Accept and emit in the same cycle -> count unchanged, no bubble.
//   count==2 -> in_ready=0; upstream must hold in_valid/data.
//  Flag derivation (at accept):
//   non-CMP: N=in_result[DATA_W-1], Z=(in_result==0), C=in_cout, V=in_overflow.
//   CMP:     N=in_cmp_n, Z=in_cmp_eq, C=in_cout (1 = no borrow), V=in_overflow;
//            out_wr_en=0. All other opcodes: out_wr_en=1.
//   Undefined opcodes (5..7): flags={N,Z,0,0}, out_wr_en=0.
//  status_flags: loads the flags of each accepted transaction at accept time,
//   not at emit time.
//  Simultaneous flag_clr and accept: accept wins (status = new flags).
//  Reset mid-stream: buffered entries discarded, no emit after rst;
//   in_ready=1 in the first cycle after rst deasserts.
//  No combinational path from any input to any output.
// CONFIGURATION
//  ALU_STICKY_OVF_EN defined: adds output sticky_ovf (1 bit).
//   - Set on any accepted transaction with V=1.
//   - Cleared only by rst or flag_clr; set wins over flag_clr in the same cycle.
//  Undefined: port absent, no sticky register.
// TESTING
//  1) ADD result=16'h0000, cout=1, ovf=0, out_ready=1
//     -> next cycle out_valid=1, out_flags=4'b0110, out_wr_en=1.
//  2) CMP in_cmp_eq=1, in_cout=1
//     -> out_wr_en=0, out_flags=4'b0110, status_flags=4'b0110.
//  3) out_ready=0, three back-to-back in_valid
//     -> two accepted, in_ready=0 on third; release -> order preserved, no loss.
//  4) Continuous in_valid/out_ready=1 for 100 ops -> 1 op/cycle, in_ready stays 1.
//  5) ADD 16'h7FFF+1 (ovf=1) then flag_clr
//     -> status 4'b1001 then 0; with ALU_STICKY_OVF_EN, sticky_ovf 1 then 0.
//  6) rst asserted with 2 entries buffered
//     -> out_valid=0 next cycle, no stale output after release.

Source files
------------

// File: rtl/alu_flag_pipeline_stage.sv
// Output stage behind the 16-bit arithmetic unit: derives N/Z/C/V flags and holds the status register.
// Results go downstream through a 2-entry skid buffer. The `ALU_STICKY_OVF_EN macro adds the sticky_ovf output.
module alu_flag_pipeline_stage #(
  parameter int DATA_W = 16,
  parameter int SKID_D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_cout,
  input  logic              in_overflow,
  input  logic              in_cmp_eq,
  input  logic              in_cmp_n,
  input  logic              flag_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_wr_en,
  output logic [3:0]        out_flags,
  output logic [3:0]        status_flags
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic              sticky_ovf
`endif
);

  typedef enum logic [2:0] {
    ARITH_ADD = 3'd0,
    ARITH_SUB = 3'd1,
    ARITH_ADC = 3'd2,
    ARITH_SBC = 3'd3,
    ARITH_CMP = 3'd4
  } arith_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              wr_en;
    logic [3:0]        flags;
  } entry_t;

  if (SKID_D != 2) begin : g_bad_depth
    $error("alu_flag_pipeline_stage: SKID_D must be 2");
  end

  entry_t     buf_q [SKID_D];
  entry_t     buf_d [SKID_D];
  entry_t     new_entry;
  entry_t     head_q, head_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] status_q, status_d;
  logic       accept, emit;
`ifdef ALU_STICKY_OVF_EN
  logic       sticky_q, sticky_d;
`endif

  always_comb begin
    accept    = in_valid & in_ready_q;
    emit      = out_valid_q & out_ready;

    new_entry        = '0;
    new_entry.result = in_result;
    if (in_ctrl == ARITH_CMP) begin
      new_entry.flags = {in_cmp_n, in_cmp_eq, in_cout, in_overflow};
      new_entry.wr_en = 1'b0;
    end else if (in_ctrl > ARITH_CMP) begin
      new_entry.flags = {in_result[DATA_W-1], (in_result == '0), 2'b00};
      new_entry.wr_en = 1'b0;
    end else begin
      new_entry.flags = {in_result[DATA_W-1], (in_result == '0), in_cout, in_overflow};
      new_entry.wr_en = 1'b1;
    end

    buf_d = buf_q;
    if (accept) buf_d[wr_ptr_q] = new_entry;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ emit;
    count_d  = count_q + {1'b0, accept} - {1'b0, emit};

    // Outputs are registered from next-state so no input reaches an output combinationally.
    in_ready_d  = (count_d < 2'd2);
    out_valid_d = (count_d != 2'd0);
    head_d      = buf_d[rd_ptr_d];

    status_d = status_q;
    if (accept)        status_d = new_entry.flags;
    else if (flag_clr) status_d = '0;

`ifdef ALU_STICKY_OVF_EN
    sticky_d = sticky_q;
    if (flag_clr)                      sticky_d = 1'b0;
    if (accept && new_entry.flags[0])  sticky_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SKID_D; i++) buf_q[i] <= '0;
      head_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      status_q    <= '0;
`ifdef ALU_STICKY_OVF_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < SKID_D; i++) buf_q[i] <= buf_d[i];
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      status_q    <= status_d;
`ifdef ALU_STICKY_OVF_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = head_q.result;
  assign out_wr_en    = head_q.wr_en;
  assign out_flags    = head_q.flags;
  assign status_flags = status_q;
`ifdef ALU_STICKY_OVF_EN
  assign sticky_ovf   = sticky_q;
`endif

endmodule

// File: tb/tb_alu_flag_pipeline_stage.sv
// Scoreboard bench for alu_flag_pipeline_stage: expected entries are queued at accept and compared at the output.
module tb_alu_flag_pipeline_stage;

  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          wr;
    logic [3:0]    fl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_ctrl = '0;
  logic [DW-1:0] in_result = '0;
  logic          in_cout = 1'b0;
  logic          in_overflow = 1'b0;
  logic          in_cmp_eq = 1'b0;
  logic          in_cmp_n = 1'b0;
  logic          flag_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_result;
  logic          out_wr_en;
  logic [3:0]    out_flags;
  logic [3:0]    status_flags;
`ifdef ALU_STICKY_OVF_EN
  logic          sticky_ovf;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  logic [3:0] m_status = '0;
  logic       m_sticky = 1'b0;

  alu_flag_pipeline_stage #(.DATA_W(DW), .SKID_D(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_result(in_result), .in_cout(in_cout),
    .in_overflow(in_overflow), .in_cmp_eq(in_cmp_eq), .in_cmp_n(in_cmp_n),
    .flag_clr(flag_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wr_en(out_wr_en), .out_flags(out_flags),
    .status_flags(status_flags)
`ifdef ALU_STICKY_OVF_EN
    , .sticky_ovf(sticky_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] ctrl, input logic [DW-1:0] res,
                                 input logic cout, input logic ovf, input logic eq, input logic n);
    exp_t e;
    e.res = res;
    case (ctrl)
      3'd4:                   begin e.fl = {n, eq, cout, ovf};                 e.wr = 1'b0; end
      3'd5, 3'd6, 3'd7:       begin e.fl = {res[DW-1], res == 16'h0, 2'b00};   e.wr = 1'b0; end
      default:                begin e.fl = {res[DW-1], res == 16'h0, cout, ovf}; e.wr = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: checks state left by the previous edge, then predicts the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_status = '0;
      m_sticky = 1'b0;
    end else begin
      automatic int  sz  = sb_q.size();
      automatic logic acc = in_valid && (sz < 2);
      automatic exp_t e;
      check_eq("out_valid", 32'(out_valid), 32'(sz != 0));
      check_eq("in_ready", 32'(in_ready), 32'(sz < 2));
      check_eq("status_flags", 32'(status_flags), 32'(m_status));
`ifdef ALU_STICKY_OVF_EN
      check_eq("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
`endif
      if (out_valid && sz > 0) begin
        check_eq("out_result", 32'(out_result), 32'(sb_q[0].res));
        check_eq("out_wr_en", 32'(out_wr_en), 32'(sb_q[0].wr));
        check_eq("out_flags", 32'(out_flags), 32'(sb_q[0].fl));
        if (out_ready) void'(sb_q.pop_front());
      end
      if (acc) begin
        e = model(in_ctrl, in_result, in_cout, in_overflow, in_cmp_eq, in_cmp_n);
        sb_q.push_back(e);
        m_status = e.fl;
      end else if (flag_clr) begin
        m_status = '0;
      end
      if (flag_clr) m_sticky = 1'b0;
      if (acc && e.fl[0]) m_sticky = 1'b1;
    end
  end

  task automatic send(input logic [2:0] ctrl, input logic [DW-1:0] res, input logic cout,
                      input logic ovf, input logic eq, input logic n);
    logic got = 1'b0;
    in_valid = 1'b1; in_ctrl = ctrl; in_result = res;
    in_cout = cout; in_overflow = ovf; in_cmp_eq = eq; in_cmp_n = n;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) check_eq("send_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_result", 32'(out_result), 32'd0);
    check_eq("rst_out_wr_en", 32'(out_wr_en), 32'd0);
    check_eq("rst_out_flags", 32'(out_flags), 32'd0);
    check_eq("rst_status", 32'(status_flags), 32'd0);

    // 1) ADD giving zero with carry
    send(3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t1_out_valid", 32'(out_valid), 32'd1);
    check_eq("t1_out_flags", 32'(out_flags), 32'b0110);
    check_eq("t1_out_wr_en", 32'(out_wr_en), 32'd1);

    // 2) CMP equal, no borrow
    send(3'd4, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("t2_out_wr_en", 32'(out_wr_en), 32'd0);
    check_eq("t2_out_flags", 32'(out_flags), 32'b0110);
    check_eq("t2_status", 32'(status_flags), 32'b0110);

    // Undefined opcode
    send(3'd6, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("undef_out_flags", 32'(out_flags), 32'b1000);
    check_eq("undef_wr_en", 32'(out_wr_en), 32'd0);

    // 3) backpressure: third transaction stalls
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    send(3'd1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
    fork
      send(3'd2, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0);
    join_none
    repeat (3) @(negedge clk);
    check_eq("t3_full_in_ready", 32'(in_ready), 32'd0);
    check_eq("t3_held_result", 32'(out_result), 32'h1111);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    repeat (4) @(posedge clk); #1;

    // 4) 100 back-to-back ops at full rate
    t0 = cyc;
    for (int i = 0; i < 100; i++)
      send(3'($urandom_range(0, 4)), 16'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    check_eq("t4_cycles", 32'(cyc - t0), 32'd100);
    repeat (3) @(posedge clk); #1;

    // 5) overflow then flag_clr
    send(3'd0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t5_status_set", 32'(status_flags), 32'b1001);
`ifdef ALU_STICKY_OVF_EN
    check_eq("t5_sticky_set", 32'(sticky_ovf), 32'd1);
`endif
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    check_eq("t5_status_clr", 32'(status_flags), 32'd0);
`ifdef ALU_STICKY_OVF_EN
    check_eq("t5_sticky_clr", 32'(sticky_ovf), 32'd0);
`endif

    // flag_clr coinciding with an accept: accept wins
    flag_clr = 1'b1;
    send(3'd1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    flag_clr = 1'b0;
    check_eq("clr_vs_accept", 32'(status_flags), 32'b0111);
`ifdef ALU_STICKY_OVF_EN
    check_eq("clr_vs_set_sticky", 32'(sticky_ovf), 32'd1);
`endif

    // 6) reset with two entries buffered
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    send(3'd0, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd1);
    check_eq("t6_status", 32'(status_flags), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t6_no_stale", 32'(out_valid), 32'd0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
